// File: rtl/mips_imem_loader_pkg.sv
// Shared types for the MIPS instruction-memory loader: formats, field bundle, loader states.
package mips_imem_loader_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_INV = 2'b11
   } instr_fmt_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_fields_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/mips_imem_loader_if.sv
// Field-beat stream from the boot source plus the imem write port driven by the loader.
interface mips_imem_loader_if #(parameter int unsigned ADDR_W = 32);
   logic              s_valid;
   logic              s_ready;
   logic [1:0]        s_fmt;
   logic [5:0]        s_opcode;
   logic [4:0]        s_rs;
   logic [4:0]        s_rt;
   logic [4:0]        s_rd;
   logic [4:0]        s_shamt;
   logic [5:0]        s_funct;
   logic [15:0]       s_imm;
   logic [25:0]       s_target;
   logic              s_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output s_valid, s_fmt, s_opcode, s_rs, s_rt, s_rd, s_shamt, s_funct,
             s_imm, s_target, s_last,
      input  s_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  s_valid, s_fmt, s_opcode, s_rs, s_rt, s_rd, s_shamt, s_funct,
             s_imm, s_target, s_last,
      output s_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// Combinational packer: instruction fields + format -> 32-bit MIPS word, flags invalid format.
module mips_instr_encoder
   import mips_imem_loader_pkg::*;
(
   input  instr_fields_t fields_i,
   input  instr_fmt_t    fmt_i,
   output logic [31:0]   word_o,
   output logic          fmt_err_o
);

   always_comb begin
      word_o    = '0;
      fmt_err_o = 1'b0;
      unique case (fmt_i)
         FMT_R:   word_o = {OP_RTYPE, fields_i.rs, fields_i.rt, fields_i.rd,
                            fields_i.shamt, fields_i.funct};
         FMT_I:   word_o = {fields_i.opcode, fields_i.rs, fields_i.rt, fields_i.imm};
         FMT_J:   word_o = {fields_i.opcode, fields_i.target};
         default: fmt_err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_imem_loader.sv
// Streams encoded instructions into imem sequentially, holding the CPU in reset until loaded.
module mips_imem_loader
   import mips_imem_loader_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DEPTH     = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   localparam int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   mips_imem_loader_if.slave    bus,
   output logic [CNT_W-1:0]     count,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 err_fmt
);

   loader_state_t     state_q, state_d;
   logic [CNT_W-1:0]  count_q;
   logic              err_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   instr_fields_t     fields;
   logic [31:0]       enc_word;
   logic              enc_err;
   logic              accept;
   logic              wr_ok;
   logic              start_load;

   assign fields = '{opcode: bus.s_opcode, rs: bus.s_rs, rt: bus.s_rt, rd: bus.s_rd,
                     shamt: bus.s_shamt, funct: bus.s_funct, imm: bus.s_imm,
                     target: bus.s_target};

   mips_instr_encoder u_enc (
      .fields_i  (fields),
      .fmt_i     (instr_fmt_t'(bus.s_fmt)),
      .word_o    (enc_word),
      .fmt_err_o (enc_err)
   );

   assign bus.s_ready = (state_q == ST_LOAD) && (count_q < CNT_W'(DEPTH));
   assign accept      = bus.s_valid && bus.s_ready;
   assign wr_ok       = accept && !enc_err;
   assign start_load  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // The final write leaves the register stage during DRAIN, so DONE follows one cycle later.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            if ((accept && bus.s_last) || (wr_ok && (count_q == CNT_W'(DEPTH - 1))))
               state_d = ST_DRAIN;
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
      end else begin
         we_q <= wr_ok;
         if (start_load) begin
            count_q <= '0;
            err_q   <= 1'b0;
         end else if (accept) begin
            if (enc_err) begin
               err_q <= 1'b1;
            end else begin
               count_q <= count_q + 1'b1;
               addr_q  <= BASE_ADDR + (ADDR_W'(count_q) << 2);
               wdata_q <= enc_word;
            end
         end
      end
   end

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign count          = count_q;
   assign err_fmt        = err_q;
   assign done           = (state_q == ST_DONE);
   assign cpu_hold       = (state_q != ST_DONE);

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader with a cycle-level reference model and literal checks.
module tb_mips_imem_loader;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] count;
   logic       cpu_hold, done, err_fmt;

   int n_checks = 0;
   int n_fail   = 0;

   mips_imem_loader_if #(.ADDR_W(32)) ifc ();

   mips_imem_loader #(.ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bus      (ifc),
      .count    (count),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err_fmt  (err_fmt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding by shifts and ORs.
   function automatic logic [31:0] model_enc(input logic [1:0] fmt);
      logic [31:0] w;
      w = 32'd0;
      if (fmt == 2'd0)
         w = (32'(ifc.s_rs) << 21) | (32'(ifc.s_rt) << 16) | (32'(ifc.s_rd) << 11) |
             (32'(ifc.s_shamt) << 6) | 32'(ifc.s_funct);
      else if (fmt == 2'd1)
         w = (32'(ifc.s_opcode) << 26) | (32'(ifc.s_rs) << 21) | (32'(ifc.s_rt) << 16) |
             32'(ifc.s_imm);
      else if (fmt == 2'd2)
         w = (32'(ifc.s_opcode) << 26) | 32'(ifc.s_target);
      return w;
   endfunction

   bit          m_load = 0, m_drain = 0, m_done = 0, m_err = 0, m_we = 0;
   int          m_words = 0;
   logic [31:0] m_addr = 0, m_wdata = 0;

   always @(posedge clk or negedge rst_n) begin
      bit rdy, acc;
      if (!rst_n) begin
         m_load = 0; m_drain = 0; m_done = 0; m_err = 0; m_we = 0;
         m_words = 0; m_addr = 0; m_wdata = 0;
      end else begin
         rdy  = m_load && (m_words < DEPTH);
         acc  = (ifc.s_valid === 1'b1) && rdy;
         m_we = 0;
         if (m_drain) begin
            m_drain = 0;
            m_done  = 1;
         end else if (m_load) begin
            if (acc) begin
               if (ifc.s_fmt == 2'd3) m_err = 1;
               else begin
                  m_we    = 1;
                  m_addr  = 32'h0 + 32'(m_words) * 4;
                  m_wdata = model_enc(ifc.s_fmt);
                  m_words++;
               end
            end
            if ((acc && ifc.s_last) || (m_words == DEPTH)) begin
               m_load  = 0;
               m_drain = 1;
            end
         end else if (start) begin
            m_load = 1; m_done = 0; m_words = 0; m_err = 0;
         end
      end
   end

   always @(negedge clk) begin
      check("s_ready",    ifc.s_ready,    64'(m_load && (m_words < DEPTH)));
      check("imem_we",    ifc.imem_we,    64'(m_we));
      check("imem_addr",  ifc.imem_addr,  64'(m_addr));
      check("imem_wdata", ifc.imem_wdata, 64'(m_wdata));
      check("count",      count,          64'(m_words));
      check("done",       done,           64'(m_done));
      check("cpu_hold",   cpu_hold,       64'(!m_done));
      check("err_fmt",    err_fmt,        64'(m_err));
   end

   logic [31:0] cap [0:255];
   int          wcount = 0;
   logic [31:0] maxaddr = 0;

   always @(negedge clk) begin
      if (ifc.imem_we === 1'b1) begin
         cap[ifc.imem_addr[9:2]] = ifc.imem_wdata;
         wcount++;
         if (ifc.imem_addr > maxaddr) maxaddr = ifc.imem_addr;
      end
   end

   task automatic clear_cap();
      wcount  = 0;
      maxaddr = 0;
      for (int i = 0; i < 256; i++) cap[i] = 32'hDEAD_BEEF;
   endtask

   task automatic set_beat(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [5:0] fn, input logic [15:0] imm,
                           input logic [25:0] tgt, input logic last);
      ifc.s_fmt = fmt; ifc.s_opcode = op; ifc.s_rs = rs; ifc.s_rt = rt; ifc.s_rd = rd;
      ifc.s_shamt = sh; ifc.s_funct = fn; ifc.s_imm = imm; ifc.s_target = tgt;
      ifc.s_last = last;
   endtask

   task automatic send(input string name);
      bit got = 0;
      ifc.s_valid = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = ifc.s_ready;
         @(posedge clk);
         #1;
      end
      ifc.s_valid = 1'b0;
      check({name, "_accepted"}, 64'(got), 64'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 50 && done !== 1'b1; i++) begin
         @(posedge clk);
         #1;
      end
      check({name, "_done_wait"}, 64'(done), 64'd1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_ready"}, ifc.s_ready,    0);
      check({name, "_we"},    ifc.imem_we,    0);
      check({name, "_addr"},  ifc.imem_addr,  0);
      check({name, "_wdata"}, ifc.imem_wdata, 0);
      check({name, "_count"}, count,          0);
      check({name, "_done"},  done,           0);
      check({name, "_err"},   err_fmt,        0);
      check({name, "_hold"},  cpu_hold,       1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      ifc.s_valid = 1'b0;
      set_beat(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      clear_cap();
      #23 check_reset_vals("reset");
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // add $3,$1,$2 as a single-beat image
      pulse_start();
      set_beat(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
      send("r_add");
      @(negedge clk);
      check("r_add_we",   ifc.imem_we, 1);
      check("r_add_done", done,        0);
      @(negedge clk);
      check("r_add_done_next", done,     1);
      check("r_add_hold",      cpu_hold, 0);
      check("r_add_word",      cap[0],   32'h0022_1820);
      check("r_add_writes",    wcount,   1);
      @(posedge clk);
      #1;

      // addi $8,$0,5 then j 0x100
      clear_cap();
      pulse_start();
      set_beat(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'd5, 26'h0, 1'b0);
      send("i_addi");
      set_beat(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h100, 1'b1);
      send("j_jump");
      wait_done("ij");
      check("ij_word0", cap[0], 32'h2008_0005);
      check("ij_word1", cap[1], 32'h0800_0100);
      check("ij_count", count,  2);

      // continuous stream without s_last stops at DEPTH
      clear_cap();
      pulse_start();
      set_beat(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 16'h0, 26'h0, 1'b0);
      ifc.s_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 ifc.s_funct = 6'(i + 1);
      end
      ifc.s_valid = 1'b0;
      wait_done("depth");
      check("depth_writes",  wcount,  4);
      check("depth_maxaddr", maxaddr, 12);
      check("depth_count",   count,   4);
      check("depth_word3",   cap[3],  32'h0085_3083);

      // invalid format between two valid beats
      clear_cap();
      pulse_start();
      set_beat(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
      send("err_b0");
      set_beat(2'd3, 6'h3F, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
      send("err_b1");
      set_beat(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'd5, 26'h0, 1'b1);
      send("err_b2");
      wait_done("err");
      check("err_flag",   err_fmt, 1);
      check("err_writes", wcount,  2);
      check("err_word0",  cap[0],  32'h0022_1820);
      check("err_word1",  cap[1],  32'h2008_0005);
      pulse_start();
      @(negedge clk);
      check("err_cleared", err_fmt, 0);
      check("err_done_lo", done,    0);
      @(posedge clk);
      #1;

      // reset in the middle of a five-beat image
      set_beat(2'd0, 6'h00, 5'd9, 5'd10, 5'd11, 5'd0, 6'h22, 16'h0, 26'h0, 1'b0);
      send("rst_b0");
      set_beat(2'd1, 6'h0D, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 1'b0);
      send("rst_b1");
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_cap();
      @(posedge clk);
      #1;
      pulse_start();
      set_beat(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h2A, 1'b1);
      send("after_rst");
      wait_done("after_rst");
      check("after_rst_word0",  cap[0],  32'h0C00_002A);
      check("after_rst_writes", wcount,  1);
      check("after_rst_addr",   maxaddr, 0);

      // s_valid held while DONE, then start
      clear_cap();
      set_beat(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
      ifc.s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("held_no_write", wcount, 0);
      pulse_start();
      @(negedge clk);
      check("held_ready", ifc.s_ready, 1);
      @(posedge clk);
      #1 ifc.s_valid = 1'b0;
      @(negedge clk);
      check("held_we",    ifc.imem_we,    1);
      check("held_addr",  ifc.imem_addr,  0);
      check("held_wdata", ifc.imem_wdata, 32'h0022_1820);
      wait_done("held");
      check("held_writes", wcount, 1);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
